button_event_scheduler: RTL and testbench

Front end for the calculator's key inputs. Synchronizes and debounces N raw buttons on one shared sampling tick, turns each debounced press into a pending event, and hands events one at a time to the calculator core through a valid/ready handshake. Simultaneous presses are arbitrated round-robin so that no button starves.

---
 rtl/button_event_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_button_event_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
// Key-input front end for the calculator: two-flop synchronizers, a shared
// debounce sampling tick, per-button press detection, sticky pending flags and
// a round-robin arbiter that offers one event at a time to the core.
//
// Handshake: event_valid/event_index are driven from flops and held stable
// while event_valid=1; an event transfers on a rising clock edge where
// event_valid=1 and event_ready=1. event_ready is don't-care while
// event_valid=0, and the scheduler returns to idle for at least one cycle
// after every transfer.
module button_event_scheduler #(
  parameter int N_BUTTONS = 4,
  parameter int TICK_DIV  = 250000,
  parameter int SAMPLES   = 3,
  parameter int IDX_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] pressed,
  output logic                 event_valid,
  output logic [IDX_W-1:0]     event_index,
  input  logic                 event_ready,
  output logic                 lost,
  output logic                 state_dbg
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Input conditioning and event bookkeeping registers.
  logic [N_BUTTONS-1:0]              sync1_q, sync1_d;
  logic [N_BUTTONS-1:0]              sync2_q, sync2_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [N_BUTTONS-1:0][SAMPLES-1:0] samp_q, samp_d;
  logic [N_BUTTONS-1:0]              prev_q, prev_d;
  logic [N_BUTTONS-1:0]              press_q, press_d;
  logic [N_BUTTONS-1:0]              pending_q, pending_d;
  logic                              lost_q, lost_d;

  // Scheduler registers.
  state_t                            state_q, state_d;
  logic                              valid_q, valid_d;
  logic [IDX_W-1:0]                  index_q, index_d;
  logic [IDX_W-1:0]                  rr_q, rr_d;

  logic                              tick;
  logic                              handshake;
  logic [N_BUTTONS-1:0]              clr;
  logic                              found_hi, found_lo;
  logic [IDX_W-1:0]                  idx_hi, idx_lo;
  logic                              any_pending;
  logic [IDX_W-1:0]                  pick_idx;

  // Debounced level: a button counts as pressed only when every sample is high,
  // so a single low sample releases it.
  always_comb begin
    pressed = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      pressed[i] = &samp_q[i];
    end
  end

  // Synchronizers, tick counter, sample shifting, edge detect and pending flags.
  always_comb begin
    sync1_d   = button;
    sync2_d   = sync1_q;
    tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    samp_d    = samp_q;
    if (tick) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        samp_d[i] = {samp_q[i][SAMPLES-2:0], sync2_q[i]};
      end
    end
    prev_d    = pressed;
    press_d   = pressed & ~prev_q;
    handshake = (state_q == OFFER) && event_ready;
    clr       = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      clr[i] = handshake && (index_q == IDX_W'(i));
    end
    // A press coinciding with its own clear re-arms the flag and is not lost.
    pending_d = (pending_q & ~clr) | press_q;
    lost_d    = |(press_q & pending_q & ~clr);
  end

  // Round-robin pick: lowest pending index at or above rr_q, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if (IDX_W'(i) >= rr_q) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = IDX_W'(i);
        end
      end
    end
    any_pending = found_hi | found_lo;
    pick_idx    = found_hi ? idx_hi : idx_lo;
  end

  // Scheduler next state: offer a picked event, hold it until accepted.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    index_d = index_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          index_d = pick_idx;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (event_ready) begin
          valid_d = 1'b0;
          rr_d    = (index_q == IDX_W'(N_BUTTONS - 1)) ? '0 : index_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      samp_q    <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      index_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      index_q <= index_d;
      rr_q    <= rr_d;
    end
  end

  assign event_valid = valid_q;
  assign event_index = index_q;
  assign lost        = lost_q;
  assign state_dbg   = (state_q == OFFER);

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler with a 4-cycle tick and 3-sample debounce.
module tb_button_event_scheduler;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SM = 3;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  button = '0;
  logic          event_ready = 1'b0;
  logic [N-1:0]  pressed;
  logic          event_valid;
  logic [IW-1:0] event_index;
  logic          lost;
  logic          state_dbg;

  button_event_scheduler #(
    .N_BUTTONS(N),
    .TICK_DIV (TD),
    .SAMPLES  (SM),
    .IDX_W    (IW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .button     (button),
    .pressed    (pressed),
    .event_valid(event_valid),
    .event_index(event_index),
    .event_ready(event_ready),
    .lost       (lost),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] mask;
    int           n_exp;
    logic [7:0]   order;
  } vec_t;

  logic [IW-1:0] exp_q[$];
  vec_t          vecs[7];
  int            n_vec = 0;
  int            n_miss = 0;
  int            ev_count = 0;
  int            lost_count = 0;

  function automatic vec_t mk(input logic [N-1:0] m, input int n,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d);
    vec_t v;
    v.mask  = m;
    v.n_exp = n;
    v.order = {d, c, b, a};
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: values seen here are what the next rising edge will act on.
  task automatic step();
    logic [IW-1:0] e;
    if (reset_n && event_valid && event_ready) begin
      ev_count++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event: got index %0d, expected no event", event_index);
      end else begin
        e = exp_q.pop_front();
        if (event_index !== e) begin
          n_miss++;
          $display("FAIL event_order: got index %0d, expected %0d", event_index, e);
        end
      end
    end
    if (reset_n && lost) lost_count++;
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_vec(input vec_t v, input int k);
    for (int j = 0; j < v.n_exp; j++) exp_q.push_back(v.order[2*j +: 2]);
    button = v.mask;
    steps(20);
    button = '0;
    steps(30);
    check($sformatf("table_%0d_drained", k), exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int pr, vr, pf, ev0, lc0, stab_err, seen_v, seen;
    logic pp, pv;

    // Rotation expectations follow the rr pointer left by each prior group.
    vecs[0] = mk(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);
    vecs[1] = mk(4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0);
    vecs[2] = mk(4'b0111, 3, 2'd0, 2'd1, 2'd2, 2'd0);
    vecs[3] = mk(4'b1111, 4, 2'd3, 2'd0, 2'd1, 2'd2);
    vecs[4] = mk(4'b0010, 1, 2'd1, 2'd0, 2'd0, 2'd0);
    vecs[5] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);
    vecs[6] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);

    // Reset held with all buttons pressed.
    button      = 4'b1111;
    event_ready = 1'b1;
    @(negedge clock);
    steps(5);
    check("reset_valid", int'(event_valid), 0);
    check("reset_index", int'(event_index), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_lost", int'(lost), 0);
    check("reset_state", int'(state_dbg), 0);

    for (int j = 0; j < N; j++) exp_q.push_back(IW'(j));
    reset_n = 1'b1;
    n = 0;
    while (!event_valid && n < 40) begin
      step();
      n++;
    end
    check("reset_first_event_timeout", int'(n < 40), 1);
    check("reset_first_event_min_latency", int'(n >= 14), 1);
    steps(20);
    button = '0;
    steps(30);
    check("reset_group_drained", exp_q.size(), 0);

    // Table of simultaneous-press groups.
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Clean press on button 2 with timing of pressed and valid.
    exp_q.push_back(2'd2);
    button = 4'b0100;
    pr = -1; vr = -1; pf = -1; pp = 1'b0; pv = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (pressed[2] && !pp && pr < 0) pr = c;
      if (!pressed[2] && pp && c > 20 && pf < 0) pf = c;
      if (event_valid && !pv && vr < 0) vr = c;
      pp = pressed[2];
      pv = event_valid;
      if (c == 20) button = '0;
    end
    check("clean_valid_after_pressed", vr - pr, 3);
    check("clean_release_first_tick", int'(pf >= 23 && pf <= 26), 1);
    check("clean_drained", exp_q.size(), 0);

    // Bounce on button 1: nothing may be delivered while it chatters.
    ev0 = ev_count;
    for (int i = 0; i < 40; i++) begin
      button[1] = ((i / 3) % 2 == 0);
      step();
    end
    check("bounce_no_event", ev_count - ev0, 0);
    exp_q.push_back(2'd1);
    button = 4'b0010;
    steps(25);
    button = '0;
    steps(30);
    check("bounce_one_event", ev_count - ev0, 1);
    check("bounce_drained", exp_q.size(), 0);

    // Backpressure: second press of a still-pending button is lost.
    event_ready = 1'b0;
    lc0 = lost_count;
    stab_err = 0;
    seen_v = 0;
    for (int c = 0; c < 70; c++) begin
      button = (c < 20 || (c >= 35 && c < 55)) ? 4'b0100 : 4'b0000;
      step();
      if (event_valid) begin
        seen_v = 1;
        if (event_index != 2'd2) stab_err++;
      end else if (seen_v != 0) begin
        stab_err++;
      end
    end
    check("bp_held_stable", stab_err, 0);
    check("bp_valid_held", int'(event_valid), 1);
    check("bp_lost_once", lost_count - lc0, 1);
    ev0 = ev_count;
    exp_q.push_back(2'd2);
    event_ready = 1'b1;
    steps(30);
    check("bp_one_event", ev_count - ev0, 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_idle_after", int'(event_valid), 0);

    // Asynchronous reset while an event is being offered.
    event_ready = 1'b0;
    button = 4'b1000;
    n = 0;
    while (!event_valid && n < 40) begin
      step();
      n++;
    end
    check("rst_offer_timeout", int'(n < 40), 1);
    check("rst_offer_index", int'(event_index), 3);
    button = '0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", int'(event_valid), 0);
    check("rst_async_index", int'(event_index), 0);
    @(negedge clock);
    steps(3);
    reset_n = 1'b1;
    event_ready = 1'b1;
    ev0 = ev_count;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (event_valid) seen = 1;
    end
    check("rst_no_events_after", ev_count - ev0, 0);
    check("rst_no_valid_after", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
